// File: rtl/qbert_frame_compositor.sv
// Raster compositor: overlays one colour-keyed 16x16 sprite on a 4x-upscaled
// background and streams the composed RGB565 frame over a valid/ready handshake.
module qbert_frame_compositor #(
  parameter int H_RES         = 240,
  parameter int V_RES         = 320,
  parameter int BG_W          = 60,
  parameter int SCALE_SHIFT   = 2,
  parameter int SPR_SIZE_LOG2 = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic [8:0]  sprite_x,
  input  logic [8:0]  sprite_y,
  input  logic [3:0]  sprite_idx,
  input  logic [15:0] key_color,
  output logic [12:0] background_mem_s2_address,
  output logic        background_mem_s2_chipselect,
  output logic        background_mem_s2_clken,
  output logic        background_mem_s2_write,
  output logic [15:0] background_mem_s2_writedata,
  output logic [1:0]  background_mem_s2_byteenable,
  input  logic [15:0] background_mem_s2_readdata,
  output logic [11:0] pic_mem_s2_address,
  output logic        pic_mem_s2_chipselect,
  output logic        pic_mem_s2_clken,
  output logic        pic_mem_s2_write,
  output logic [15:0] pic_mem_s2_writedata,
  output logic [1:0]  pic_mem_s2_byteenable,
  input  logic [15:0] pic_mem_s2_readdata,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, OUT} state_t;

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [8:0]  spr_x_q, spr_x_d, spr_y_q, spr_y_d;
  logic [3:0]  spr_idx_q, spr_idx_d;
  logic [15:0] key_q, key_d;
  logic        hit_q, hit_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_last_q, pix_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic signed [9:0] dx, dy;
  logic              hit;
  logic [12:0]       bg_row, bg_col;
  logic              fetch;

  // Sprite-relative offsets; the signed 10-bit range covers every x - sprite_x.
  assign dx  = $signed({1'b0, x_q}) - $signed({1'b0, spr_x_q});
  assign dy  = $signed({1'b0, y_q}) - $signed({1'b0, spr_y_q});
  assign hit = (dx[9:SPR_SIZE_LOG2] == '0) && (dy[9:SPR_SIZE_LOG2] == '0);

  assign bg_row = 13'(y_q >> SCALE_SHIFT);
  assign bg_col = 13'(x_q >> SCALE_SHIFT);
  assign fetch  = (state_q == FETCH);

  assign background_mem_s2_address    = bg_row * 13'(BG_W) + bg_col;
  assign background_mem_s2_chipselect = fetch;
  assign background_mem_s2_clken      = fetch;
  assign background_mem_s2_write      = 1'b0;
  assign background_mem_s2_writedata  = 16'h0000;
  assign background_mem_s2_byteenable = 2'b11;

  assign pic_mem_s2_address    = {spr_idx_q, dy[SPR_SIZE_LOG2-1:0], dx[SPR_SIZE_LOG2-1:0]};
  assign pic_mem_s2_chipselect = fetch;
  assign pic_mem_s2_clken      = fetch;
  assign pic_mem_s2_write      = 1'b0;
  assign pic_mem_s2_writedata  = 16'h0000;
  assign pic_mem_s2_byteenable = 2'b11;

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_last  = pix_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    spr_x_d     = spr_x_q;
    spr_y_d     = spr_y_q;
    spr_idx_d   = spr_idx_q;
    key_d       = key_q;
    hit_d       = hit_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          spr_x_d   = sprite_x;
          spr_y_d   = sprite_y;
          spr_idx_d = sprite_idx;
          key_d     = key_color;
          x_d       = '0;
          y_d       = '0;
          busy_d    = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        hit_d   = hit;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (hit_q && (pic_mem_s2_readdata != key_q))
          pix_data_d = pic_mem_s2_readdata;
        else
          pix_data_d = background_mem_s2_readdata;
        pix_valid_d = 1'b1;
        pix_last_d  = (x_q == 9'(H_RES - 1)) && (y_q == 9'(V_RES - 1));
        state_d     = OUT;
      end
      OUT: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_last_q) begin
            pix_last_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            if (x_q == 9'(H_RES - 1)) begin
              x_d = '0;
              y_d = y_q + 9'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_idx_q   <= '0;
      key_q       <= '0;
      hit_q       <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      spr_x_q     <= spr_x_d;
      spr_y_q     <= spr_y_d;
      spr_idx_q   <= spr_idx_d;
      key_q       <= key_d;
      hit_q       <= hit_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: doc/qbert_frame_compositor.md
Name: qbert_frame_compositor

Overview:
- Raster compositor for the Q*bert LT24 display path.
- Reads the low-res background image through the background_mem s2 port and one 16x16 sprite through the pic_mem s2 port.
- Overlays the sprite on the 4x-upscaled background with colour-key transparency.
- Emits a 240x320 RGB565 pixel stream with valid/ready handshake to the LCD writer.

Parameters:
- H_RES, 240, output pixels per line
- V_RES, 320, output lines per frame
- BG_W, 60, background words per line (H_RES >> SCALE_SHIFT)
- SCALE_SHIFT, 2, background upscale factor as log2
- SPR_SIZE_LOG2, 4, sprite edge as log2 (16 pixels)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin frame
- sprite_x  in  9  sprite left column, latched at start
- sprite_y  in  9  sprite top line, latched at start
- sprite_idx  in  4  sprite number in pic_mem, latched at start
- key_color  in  16  transparent colour, latched at start
- background_mem_s2_address  out  13  background word address
- background_mem_s2_chipselect  out  1  read strobe
- background_mem_s2_clken  out  1  memory clock enable
- background_mem_s2_write  out  1  tied 0
- background_mem_s2_writedata  out  16  tied 0
- background_mem_s2_byteenable  out  2  tied 2'b11
- background_mem_s2_readdata  in  16  background pixel
- pic_mem_s2_address  out  12  sprite word address
- pic_mem_s2_chipselect  out  1  read strobe
- pic_mem_s2_clken  out  1  memory clock enable
- pic_mem_s2_write  out  1  tied 0
- pic_mem_s2_writedata  out  16  tied 0
- pic_mem_s2_byteenable  out  2  tied 2'b11
- pic_mem_s2_readdata  in  16  sprite pixel
- pix_data  out  16  composed RGB565 pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts
- pix_last  out  1  final pixel of frame, qualified by pix_valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset values: all outputs 0, except both byteenables = 2'b11.
- Reset clears the state machine to IDLE and clears the x/y counters. Reset mid-frame abandons the frame, and no done pulse is issued.
- FSM states: IDLE, FETCH, CAPTURE, OUT.
- IDLE:
  - On start: latch sprite_x, sprite_y, sprite_idx and key_color; x=0, y=0; busy=1; go to FETCH.
  - start while busy is ignored.
- FETCH (1 cycle): drive both chipselects and clkens high.
  - bg address = (y>>SCALE_SHIFT)*BG_W + (x>>SCALE_SHIFT), 13 bits; maximum 4799.
  - dx = x - sprite_x, dy = y - sprite_y, 10-bit signed.
  - hit = (0 <= dx < 16) and (0 <= dy < 16).
  - sprite address = {sprite_idx, dy[3:0], dx[3:0]}. When hit=0 the address is don't-care but still in range.
  - Register hit. Go to CAPTURE.
- CAPTURE (1 cycle, memory read latency 1): sample both readdata buses.
  - pix_data = sprite word if (hit and sprite word != key_color), else background word.
  - pix_valid=1; pix_last=1 when x=H_RES-1 and y=V_RES-1. Go to OUT.
  - Chipselect and clken are low in every state except FETCH.
- OUT: hold pix_data, pix_valid and pix_last stable until pix_ready=1.
  - On the accept cycle: pix_valid=0.
  - If pix_last: pix_last=0, busy=0, done=1 for one cycle, go to IDLE.
  - Otherwise advance: x+1, or x=0 and y+1 when x=H_RES-1; go to FETCH.
- pix_ready already high on entry to OUT is accepted that same cycle.
- Throughput: 3 cycles per pixel with pix_ready held high; 230400 cycles per frame.
- Sprite clipping:
  - Partially off-screen sprites (sprite_x > 224 or sprite_y > 304) are clipped naturally.
  - A sprite fully off-screen (sprite_x >= 240 or sprite_y >= 320) produces a pure background frame.
- Sprite edge pixels: a sprite pixel whose value equals key_color always shows the background.

Test Plan:
- Reset, then start with sprite_x=500 and pix_ready=1. Background word n = n. Required: pixel (x=7, y=5) = 1*60 + 1 = 61; pixel (239, 319) = 79*60 + 59 = 4799 with pix_last=1; done pulses 1 cycle after that accept; busy falls.
- sprite_x=10, sprite_y=20, sprite_idx=3, pic word = address, key 16'hFFFF. Required: pixel (10,20) = 768; (25,35) = 1023; (9,20) and (26,20) = background.
- Same as previous, with pic word 0x318 loaded as 16'hFFFF and key_color=16'hFFFF. Required: pixel (18,21) shows background word 5*60 + 4 = 304.
- pix_ready low for 10 cycles at pixel 100. Required: pix_data, pix_valid and pix_last stable; no chipselect activity; no counter advance.
- Second start pulse mid-frame. Required: ignored; the frame completes with exactly 76800 accepts.
- Reset_reset_n asserted mid-frame. Required: all outputs return to reset values immediately; no done pulse; a subsequent start begins at pixel (0,0).
